// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants.
// Used by the receiver and by the transmitter side.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_START  = OVERSAMPLE / 2 - 1;
   localparam int LAST_TICK  = OVERSAMPLE - 1;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Single-bit two-flop synchroniser.
// The reset value is a parameter so idle-high lines come up idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {2{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, LSB first, one start bit,
// DBIT data bits and a stop window of SB_TICK oversample ticks.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            frame_err
);

   localparam int S_MAX =
      (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
   localparam int SW = $clog2(S_MAX);
   localparam int NW = $clog2(DBIT);

   localparam logic [SW-1:0] S_MID  = SW'(MID_START);
   localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   logic rx_s;

   rx_state_t       state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            ferr_q, ferr_d;
   logic            done_q, done_d;

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (rx),
      .q    (rx_s)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  // Line back high at mid start: a glitch.
                  state_d = rx_s ? IDLE : DATA;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP) begin
                  state_d = IDLE;
                  s_d     = '0;
                  dout_d  = b_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
      end
   end

   assign rx_done_tick = done_q;
   assign dout         = dout_q;
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against two receiver
// configurations, with a frame-level expected-result model.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx1 = 1'b1;
   logic       rx2 = 1'b1;
   logic       s_tick = 1'b0;
   logic       done1, done2;
   logic       ferr1, ferr2;
   logic [7:0] dout1;
   logic [6:0] dout2;

   int checks = 0;
   int failures = 0;
   int period = 4;
   int jitter = 0;
   int jit = 0;
   int tcnt = 0;
   int sel = 0;

   int         n_done1 = 0;
   int         n_done2 = 0;
   logic [7:0] got_d1 = '0;
   logic       got_e1 = 1'b0;
   logic [6:0] got_d2 = '0;
   logic       got_e2 = 1'b0;

   int         exp_n1 = 0;
   logic [7:0] exp_d1 = '0;
   logic       exp_e1 = 1'b0;

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx1),
      .s_tick      (s_tick),
      .rx_done_tick(done1),
      .dout        (dout1),
      .frame_err   (ferr1)
   );

   uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx2),
      .s_tick      (s_tick),
      .rx_done_tick(done2),
      .dout        (dout2),
      .frame_err   (ferr2)
   );

   always #5 clk = ~clk;

   // One-clock strobe every period(+jitter) clocks.
   always @(negedge clk) begin
      if (tcnt >= period - 1 + jit) begin
         s_tick = 1'b1;
         tcnt = 0;
         jit = (jitter > 0) ? $urandom_range(0, jitter) : 0;
      end else begin
         s_tick = 1'b0;
         tcnt++;
      end
   end

   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         n_done1++;
         got_d1 = dout1;
         got_e1 = ferr1;
      end
      if (done2 === 1'b1) begin
         n_done2++;
         got_d2 = dout2;
         got_e2 = ferr2;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp_v);
      end
   endtask

   task automatic wait_tick();
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic line(input logic v, input int t);
      if (sel == 0) rx1 = v;
      else rx2 = v;
      repeat (t) wait_tick();
   endtask

   task automatic send_bits(input logic [7:0] d, input int nb);
      line(1'b0, 16);
      for (int i = 0; i < nb; i++) line(d[i], 16);
   endtask

   // Model: a frame yields its data bits and the inverted stop level.
   task automatic frame1(input logic [7:0] d, input bit bad,
                         input int gap, input string tag);
      sel = 0;
      send_bits(d, 8);
      if (bad) begin
         line(1'b0, 12);
         line(1'b1, 20);
      end else begin
         line(1'b1, 16);
         if (gap > 0) line(1'b1, gap);
      end
      exp_n1++;
      exp_d1 = d;
      exp_e1 = bad;
      settle();
      chk({tag, "_cnt"}, 32'(n_done1), 32'(exp_n1));
      chk({tag, "_dout"}, 32'(got_d1), 32'(exp_d1));
      chk({tag, "_ferr"}, 32'(got_e1), 32'(exp_e1));
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout1", 32'(dout1), 32'h0);
      chk("rst_done1", 32'(done1), 32'h0);
      chk("rst_ferr1", 32'(ferr1), 32'h0);
      chk("rst_dout2", 32'(dout2), 32'h0);
      reset = 1'b0;
      line(1'b1, 4);

      frame1(8'hA5, 1'b0, 8, "base");

      sel = 0;
      line(1'b0, 3);
      line(1'b1, 20);
      settle();
      chk("fstart_cnt", 32'(n_done1), 32'(exp_n1));
      chk("fstart_dout", 32'(dout1), 32'(exp_d1));

      frame1(8'h3C, 1'b1, 0, "ferr");
      frame1(8'h00, 1'b0, 0, "b2b0");
      frame1(8'hFF, 1'b0, 4, "b2b1");

      sel = 0;
      send_bits(8'h81, 4);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      line(1'b1, 20);
      settle();
      chk("abort_cnt", 32'(n_done1), 32'(exp_n1));
      chk("abort_dout", 32'(dout1), 32'h0);
      chk("abort_ferr", 32'(ferr1), 32'h0);
      frame1(8'h5A, 1'b0, 4, "after_rst");

      jitter = 2;
      for (int k = 0; k < 10; k++) begin
         frame1(8'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 2), "rnd");
      end

      period = 67;
      sel = 1;
      line(1'b1, 2);
      send_bits(8'h55, 7);
      line(1'b1, 23);
      settle();
      chk("p2_early", 32'(n_done2), 32'h0);
      line(1'b1, 1);
      settle();
      chk("p2_cnt", 32'(n_done2), 32'h1);
      chk("p2_dout", 32'(got_d2), 32'h55);
      chk("p2_ferr", 32'(got_e2), 32'h0);
      line(1'b1, 12);
      chk("p2_single", 32'(n_done2), 32'h1);
      chk("p2_quiet1", 32'(n_done1), 32'(exp_n1));

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
